// File: rtl/sine_wave_generator.sv
// sine_wave_generator: DDS sine source built from a phase accumulator and a quarter-wave ROM.
// Optional macro SINE_GEN_FREQ_PORT_EN adds a runtime freq_word increment input.
module sine_wave_generator #(
    parameter int              PHASE_W   = 32,
    parameter longint unsigned PHASE_INC = 64'd16777216
) (
    input  logic               clk,
    input  logic               rst,
`ifdef SINE_GEN_FREQ_PORT_EN
    input  logic [PHASE_W-1:0] freq_word,
`endif
    output logic [15:0]        sine_wave
);

    logic [PHASE_W-1:0] r_phase;
    logic [PHASE_W-1:0] w_inc;
    logic [7:0]         w_idx;
    logic [1:0]         w_q;
    logic [5:0]         w_a;
    logic [6:0]         w_addr;
    logic [14:0]        w_mag;
    logic [15:0]        w_pos;
    logic [15:0]        w_sample;

`ifdef SINE_GEN_FREQ_PORT_EN
    assign w_inc = freq_word;
`else
    assign w_inc = PHASE_W'(PHASE_INC);
`endif

    // Top 8 phase bits select one of 256 points; lower bits are truncated.
    assign w_idx = r_phase[PHASE_W-1 -: 8];
    assign w_q   = w_idx[7:6];
    assign w_a   = w_idx[5:0];

    // Odd quadrants walk the quarter table backwards.
    assign w_addr = w_q[0] ? (7'd64 - {1'b0, w_a}) : {1'b0, w_a};

    // Quarter-wave table: round(32767*sin(2*pi*k/256)), k = 0..64.
    always_comb begin
        w_mag = 15'd0;
        case (w_addr)
            7'd0:  w_mag = 15'd0;
            7'd1:  w_mag = 15'd804;
            7'd2:  w_mag = 15'd1608;
            7'd3:  w_mag = 15'd2410;
            7'd4:  w_mag = 15'd3212;
            7'd5:  w_mag = 15'd4011;
            7'd6:  w_mag = 15'd4808;
            7'd7:  w_mag = 15'd5602;
            7'd8:  w_mag = 15'd6393;
            7'd9:  w_mag = 15'd7179;
            7'd10: w_mag = 15'd7962;
            7'd11: w_mag = 15'd8739;
            7'd12: w_mag = 15'd9512;
            7'd13: w_mag = 15'd10278;
            7'd14: w_mag = 15'd11039;
            7'd15: w_mag = 15'd11793;
            7'd16: w_mag = 15'd12539;
            7'd17: w_mag = 15'd13279;
            7'd18: w_mag = 15'd14010;
            7'd19: w_mag = 15'd14732;
            7'd20: w_mag = 15'd15446;
            7'd21: w_mag = 15'd16151;
            7'd22: w_mag = 15'd16846;
            7'd23: w_mag = 15'd17530;
            7'd24: w_mag = 15'd18204;
            7'd25: w_mag = 15'd18868;
            7'd26: w_mag = 15'd19519;
            7'd27: w_mag = 15'd20159;
            7'd28: w_mag = 15'd20787;
            7'd29: w_mag = 15'd21403;
            7'd30: w_mag = 15'd22005;
            7'd31: w_mag = 15'd22594;
            7'd32: w_mag = 15'd23170;
            7'd33: w_mag = 15'd23731;
            7'd34: w_mag = 15'd24279;
            7'd35: w_mag = 15'd24811;
            7'd36: w_mag = 15'd25329;
            7'd37: w_mag = 15'd25832;
            7'd38: w_mag = 15'd26319;
            7'd39: w_mag = 15'd26790;
            7'd40: w_mag = 15'd27245;
            7'd41: w_mag = 15'd27683;
            7'd42: w_mag = 15'd28105;
            7'd43: w_mag = 15'd28510;
            7'd44: w_mag = 15'd28898;
            7'd45: w_mag = 15'd29268;
            7'd46: w_mag = 15'd29621;
            7'd47: w_mag = 15'd29956;
            7'd48: w_mag = 15'd30273;
            7'd49: w_mag = 15'd30571;
            7'd50: w_mag = 15'd30852;
            7'd51: w_mag = 15'd31113;
            7'd52: w_mag = 15'd31356;
            7'd53: w_mag = 15'd31580;
            7'd54: w_mag = 15'd31785;
            7'd55: w_mag = 15'd31971;
            7'd56: w_mag = 15'd32137;
            7'd57: w_mag = 15'd32285;
            7'd58: w_mag = 15'd32412;
            7'd59: w_mag = 15'd32521;
            7'd60: w_mag = 15'd32609;
            7'd61: w_mag = 15'd32678;
            7'd62: w_mag = 15'd32728;
            7'd63: w_mag = 15'd32757;
            7'd64: w_mag = 15'd32767;
            default: w_mag = 15'd0;
        endcase
    end

    // Lower half-cycle is the negated magnitude; table peak 32767 keeps this overflow-free.
    assign w_pos    = {1'b0, w_mag};
    assign w_sample = w_q[1] ? (16'd0 - w_pos) : w_pos;

    // Phase accumulator, wraps silently modulo 2**PHASE_W.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_phase <= '0;
        end else begin
            r_phase <= r_phase + w_inc;
        end
    end

    // Output register: sample of the phase present before this edge.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sine_wave <= 16'd0;
        end else begin
            sine_wave <= w_sample;
        end
    end

endmodule

// File: tb/tb_sine_wave_generator.sv
// tb_sine_wave_generator: directed + randomized checks of the DDS sine source
// against a real-valued sine reference model.
module tb_sine_wave_generator;

    localparam real PI = 3.14159265358979323846;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [15:0] sine_wave;
    logic [15:0] sine_fast;
`ifdef SINE_GEN_FREQ_PORT_EN
    logic [31:0] freq_word = 32'd16777216;
    logic [31:0] freq_fast = 32'd33554432;
`endif

    int          total = 0;
    int          bad   = 0;
    logic [31:0] ph0   = '0;
    logic [31:0] ph1   = '0;
    int          exp0  = 0;
    int          exp1  = 0;
    int          edge_n = 0;
    bit          rec   = 1'b0;
    int          hist[$];

    always #5 clk = ~clk;

    sine_wave_generator #(
        .PHASE_W(32),
        .PHASE_INC(64'd16777216)
    ) u_dut (
        .clk(clk),
        .rst(rst),
`ifdef SINE_GEN_FREQ_PORT_EN
        .freq_word(freq_word),
`endif
        .sine_wave(sine_wave)
    );

    sine_wave_generator #(
        .PHASE_W(32),
        .PHASE_INC(64'd33554432)
    ) u_fast (
        .clk(clk),
        .rst(rst),
`ifdef SINE_GEN_FREQ_PORT_EN
        .freq_word(freq_fast),
`endif
        .sine_wave(sine_fast)
    );

    // Ideal sine sampled at 256 points per period, rounded half away from zero.
    function automatic int sref(input logic [31:0] ph);
        real x;
        x = 32767.0 * $sin(2.0 * PI * real'(int'(ph[31:24])) / 256.0);
        if (x >= 0.0) return $rtoi(x + 0.5);
        return -$rtoi(0.5 - x);
    endfunction

    function automatic logic [31:0] inc0();
`ifdef SINE_GEN_FREQ_PORT_EN
        return freq_word;
`else
        return 32'd16777216;
`endif
    endfunction

    function automatic int s0();
        return int'($signed(sine_wave));
    endfunction

    function automatic int s1();
        return int'($signed(sine_fast));
    endfunction

    task automatic chk(input string tag, input int obs, input int expv);
        total++;
        assert (obs === expv) else begin
            bad++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, expv);
        end
    endtask

    // One clock edge: advance the model, then compare both instances.
    task automatic step();
        @(posedge clk);
        if (rst) begin
            exp0 = sref(ph0);
            exp1 = sref(ph1);
            ph0  = ph0 + inc0();
            ph1  = ph1 + 32'd33554432;
            edge_n++;
        end else begin
            exp0 = 0;
            exp1 = 0;
            ph0  = '0;
            ph1  = '0;
            edge_n = 0;
        end
        #1;
        chk("model", s0(), exp0);
        chk("model_fast", s1(), exp1);
        if (rec) hist.push_back(s0());
    endtask

    // Assert reset mid-cycle and check the output clears without a clock edge.
    task automatic async_reset(input int hold);
        #($urandom_range(1, 3));
        rst = 1'b0;
        #1;
        chk("async_rst", s0(), 0);
        chk("async_rst_fast", s1(), 0);
        for (int i = 0; i < hold; i++) step();
        rst = 1'b1;
    endtask

    int kn[7] = '{1, 2, 33, 65, 129, 193, 257};
    int kv[7] = '{0, 804, 23170, 32767, 0, -32767, 0};
    int mx;
    int mn;

    initial begin
        // Reset held low for 3 clocks.
        #2;
        rst = 1'b0;
        #1;
        chk("rst_init", s0(), 0);
        for (int i = 0; i < 3; i++) step();

        // Release and record 512 samples.
        rst = 1'b1;
        rec = 1'b1;
        for (int n = 1; n <= 512; n++) begin
            step();
            for (int k = 0; k < 7; k++)
                if (edge_n == kn[k]) chk("seq_const", s0(), kv[k]);
            if (edge_n == 33) chk("fast_edge33", s1(), 32767);
        end
        rec = 1'b0;

        // Symmetry and period properties of the recorded run.
        for (int n = 0; n < 384; n += 7)
            chk("half_neg", hist[n + 128], -hist[n]);
        for (int a = 0; a <= 64; a += 4)
            chk("quarter_mirror", hist[64 + a], hist[64 - a]);
        for (int n = 0; n < 256; n += 5)
            chk("period256", hist[n + 256], hist[n]);
        mx = -100000;
        mn = 100000;
        foreach (hist[i]) begin
            if (hist[i] > mx) mx = hist[i];
            if (hist[i] < mn) mn = hist[i];
        end
        chk("max", mx, 32767);
        chk("min", mn, -32767);

        // Reset mid-run at edge 100.
        async_reset(2);
        for (int n = 0; n < 100; n++) step();
        async_reset(1);
        step();
        chk("restart0", s0(), 0);
        step();
        chk("restart1", s0(), 804);

        // Random run lengths, reset points and hold times.
        for (int r = 0; r < 4; r++) begin
            for (int n = 0; n < int'($urandom_range(1, 300)); n++) step();
            async_reset(int'($urandom_range(1, 4)));
            step();
            chk("rnd_restart0", s0(), 0);
            step();
            chk("rnd_restart1", s0(), 804);
        end

`ifdef SINE_GEN_FREQ_PORT_EN
        // Freeze by zero frequency word.
        async_reset(2);
        freq_word = 32'd16777216;
        for (int n = 0; n < 8; n++) step();
        freq_word = 32'd0;
        for (int n = 9; n <= 20; n++) begin
            step();
            if (edge_n >= 10) chk("freeze", s0(), 6393);
        end
        // Random frequency words, phase stays continuous.
        for (int n = 0; n < 300; n++) begin
            freq_word = $urandom();
            if (n % 5 == 0) freq_word = 32'd0;
            step();
        end
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
